// File: rtl/seq_controller.sv
// Instruction-sequence controller for the basic RISC: decodes the phase
// stream with the opcode and zero flag into datapath strobes, handles
// halt/resume, watches the phase order and counts retired instructions.
module seq_controller #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic [1:0]       PHASE,
    input  logic [2:0]       OPCODE,
    input  logic             ZERO,
    input  logic             GO,
    output logic             EN,
    output logic             SEL,
    output logic             RD,
    output logic             LD_IR,
    output logic             INC_PC,
    output logic             LD_PC,
    output logic             DATA_E,
    output logic             LD_AC,
    output logic             WR,
    output logic             HALT,
    output logic             SEQ_ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_DECODE  = 2'd1,
        PH_EXECUTE = 2'd2,
        PH_UPDATE  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    phase_e           phase;
    opcode_e          op;
    logic             aluop;
    logic             halt_hit;

    logic             halt_q, halt_d;
    logic             zero_q, zero_d;
    phase_e           exp_q, exp_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign phase = phase_e'(PHASE);
    assign op    = opcode_e'(OPCODE);
    assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    // An HLT freezes the phaser in DECODE the very cycle it is decoded,
    // unless a resume pulse arrives at the same time.
    assign halt_hit = (phase == PH_DECODE) && (op == OP_HLT) && !GO;
    assign EN       = GO || (!halt_q && !halt_hit);

    // Strobe decode; write-like strobes are qualified by EN so nothing repeats while frozen.
    always_comb begin
        SEL    = 1'b0;
        RD     = 1'b0;
        LD_IR  = 1'b0;
        INC_PC = 1'b0;
        LD_PC  = 1'b0;
        DATA_E = 1'b0;
        LD_AC  = 1'b0;
        WR     = 1'b0;
        case (phase)
            PH_FETCH: begin
                SEL   = 1'b1;
                RD    = 1'b1;
                LD_IR = EN;
            end
            PH_DECODE: begin
                RD     = aluop;
                INC_PC = EN;
            end
            PH_EXECUTE: begin
                RD     = aluop;
                LD_AC  = aluop && EN;
                DATA_E = (op == OP_STO) && EN;
                WR     = (op == OP_STO) && EN;
                LD_PC  = (op == OP_JMP) && EN;
            end
            default: begin
                SEL    = 1'b1;
                INC_PC = (op == OP_SKZ) && zero_q && EN;
            end
        endcase
    end

    // Next-state for halt, zero capture, phase checker and retired counter.
    always_comb begin
        halt_d    = halt_q;
        zero_d    = zero_q;
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        cnt_d     = cnt_q;
        if (GO) begin
            halt_d = 1'b0;
        end else if (halt_hit) begin
            halt_d = 1'b1;
        end
        if ((phase == PH_DECODE) && EN) begin
            zero_d = ZERO;
        end
        if (EN) begin
            exp_d = phase_e'(exp_q + 2'd1);
        end
        if (phase != exp_q) begin
            seq_err_d = 1'b1;
        end
        if ((phase == PH_UPDATE) && EN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset abandons any instruction in flight, halted or not.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            halt_q    <= 1'b0;
            zero_q    <= 1'b0;
            exp_q     <= PH_FETCH;
            seq_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            halt_q    <= halt_d;
            zero_q    <= zero_d;
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign HALT      = halt_q;
    assign SEQ_ERR   = seq_err_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: a driver plays the phase generator,
// predicts each cycle's outputs from a behavioural model and queues them;
// a monitor compares the DUT against the queue on the falling edge.
module tb_seq_controller;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST_ = 1'b0;
    logic [1:0]       PHASE = 2'd0;
    logic [2:0]       OPCODE = 3'd0;
    logic             ZERO = 1'b0;
    logic             GO = 1'b0;
    logic             EN, SEL, RD, LD_IR, INC_PC, LD_PC, DATA_E, LD_AC, WR;
    logic             HALT, SEQ_ERR;
    logic [CNT_W-1:0] INSTR_CNT;

    seq_controller #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_(RST_), .PHASE(PHASE), .OPCODE(OPCODE), .ZERO(ZERO), .GO(GO),
        .EN(EN), .SEL(SEL), .RD(RD), .LD_IR(LD_IR), .INC_PC(INC_PC), .LD_PC(LD_PC),
        .DATA_E(DATA_E), .LD_AC(LD_AC), .WR(WR), .HALT(HALT), .SEQ_ERR(SEQ_ERR),
        .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [8:0] strb;   // EN SEL RD LD_IR INC_PC LD_PC DATA_E LD_AC WR
        logic       halt;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    // Behavioural model state: what the machine "knows" between edges.
    int   ph = 0;          // phase the generator will present
    bit   m_halted = 0;
    bit   m_zero = 0;
    int   m_expect = 0;    // phase the checker expects next
    bit   m_err = 0;
    int   m_count = 0;     // retired instructions modulo 16

    // Monitor: every cycle the DUT presents one set of outputs.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] s;
            e = exp_q.pop_front();
            s = {EN, SEL, RD, LD_IR, INC_PC, LD_PC, DATA_E, LD_AC, WR};
            tests++;
            if (s !== e.strb) begin
                fails++;
                $display("FAIL strobes cyc=%0d ph=%0d op=%0d got=%b want=%b", cycle, PHASE, OPCODE, s, e.strb);
            end
            tests++;
            if ({HALT, SEQ_ERR} !== {e.halt, e.err}) begin
                fails++;
                $display("FAIL status cyc=%0d halt/err got=%b%b want=%b%b", cycle, HALT, SEQ_ERR, e.halt, e.err);
            end
            tests++;
            if (INSTR_CNT !== e.cnt) begin
                fails++;
                $display("FAIL instr_cnt cyc=%0d got=%0d want=%0d", cycle, INSTR_CNT, e.cnt);
            end
            $display("[TB] cyc=%0d rst_n=%0b ph=%0d op=%0d go=%0b strb=%b halt=%0b err=%0b cnt=%0d",
                     cycle, RST_, PHASE, OPCODE, GO, s, HALT, SEQ_ERR, INSTR_CNT);
        end
    end

    // One clock cycle: drive inputs, predict outputs, advance the model across the edge.
    // force_ph < 0 means present the generator's own phase.
    task automatic step(input int op, input bit z, input bit go, input int force_ph, input bit rst_n);
        int   p;
        bit   en, alu, hit;
        exp_t e;
        bit   sel, rd, ldir, inc, ldpc, dat, ldac, wr;
        RST_ = rst_n;
        if (!rst_n) begin
            m_halted = 0; m_zero = 0; m_expect = 0; m_err = 0; m_count = 0; ph = 0;
        end
        p = (force_ph >= 0) ? force_ph : ph;
        PHASE = 2'(p); OPCODE = 3'(op); ZERO = z; GO = go;
        alu = (op >= 2 && op <= 5);
        hit = (p == 1) && (op == 0) && !go;
        en  = go || (!m_halted && !hit);
        sel = 0; rd = 0; ldir = 0; inc = 0; ldpc = 0; dat = 0; ldac = 0; wr = 0;
        case (p)
            0: begin sel = 1; rd = 1; ldir = en; end
            1: begin rd = alu; inc = en; end
            2: begin rd = alu; ldac = alu && en; dat = (op == 6) && en; wr = dat; ldpc = (op == 7) && en; end
            default: begin sel = 1; inc = (op == 1) && m_zero && en; end
        endcase
        e.strb = {en, sel, rd, ldir, inc, ldpc, dat, ldac, wr};
        e.halt = m_halted;
        e.err  = m_err;
        e.cnt  = 4'(m_count);
        exp_q.push_back(e);
        // State after the coming rising edge.
        if (rst_n) begin
            if (go) m_halted = 0;
            else if (hit) m_halted = 1;
            if (p == 1 && en) m_zero = z;
            if (p != m_expect) m_err = 1;
            if (p == 3 && en) m_count = (m_count + 1) % 16;
            if (en) m_expect = (m_expect + 1) % 4;
            ph = en ? (p + 1) % 4 : p;
        end
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    // A full instruction from FETCH; zd is ZERO during DECODE, zo otherwise.
    task automatic run_instr(input int op, input bit zd, input bit zo);
        for (int i = 0; i < 4; i++) step(op, (ph == 1) ? zd : zo, 1'b0, -1, 1'b1);
    endtask

    // HLT frozen in DECODE for nfreeze extra cycles, then a GO resume.
    task automatic run_halt(input int nfreeze);
        step(0, 1'b0, 1'b0, -1, 1'b1);                           // FETCH
        step(0, 1'b0, 1'b0, -1, 1'b1);                           // DECODE, halts
        for (int i = 0; i < nfreeze; i++) step(0, 1'b0, 1'b0, -1, 1'b1);
        step(0, 1'b0, 1'b1, -1, 1'b1);                           // GO resume
        step(0, 1'b0, 1'b0, -1, 1'b1);                           // EXECUTE
        step(0, 1'b0, 1'b0, -1, 1'b1);                           // UPDATE
    endtask

    initial begin
        int hold;
        int op;
        @(posedge CLK);
        #1;
        // Reset state, then released.
        step(0, 1'b0, 1'b0, -1, 1'b0);
        step(0, 1'b0, 1'b0, -1, 1'b0);
        // Basic ALU op, store, jump.
        run_instr(2, 1'b0, 1'b0);
        run_instr(6, 1'b0, 1'b0);
        run_instr(7, 1'b0, 1'b0);
        // Skip-on-zero: taken, then not taken.
        run_instr(1, 1'b1, 1'b0);
        run_instr(1, 1'b0, 1'b1);
        // Halt with 5 frozen cycles and resume.
        run_halt(5);
        run_instr(5, 1'b1, 1'b0);
        // Randomized instruction stream with halts and stray GO pulses.
        hold = 0;
        op = 0;
        for (int c = 0; c < 400; c++) begin
            bit go;
            if (ph == 0) op = $urandom_range(0, 7);
            go = 0;
            if (m_halted) begin
                if (hold == 0) hold = $urandom_range(1, 6);
                hold--;
                go = (hold == 0);
            end else begin
                go = ($urandom_range(0, 15) == 0);
            end
            step(op, 1'($urandom), go, -1, 1'b1);
        end
        // Finish any instruction in flight, resuming if halted.
        while (ph != 0 || m_halted) step(3, 1'b0, m_halted, -1, 1'b1);
        // Phase-order error: FETCH then EXECUTE, sticky afterwards.
        step(2, 1'b0, 1'b0, -1, 1'b1);
        step(2, 1'b0, 1'b0, 2, 1'b1);
        step(2, 1'b0, 1'b0, -1, 1'b1);
        for (int i = 0; i < 8; i++) step(4, 1'b0, 1'b0, -1, 1'b1);
        // Reset, then 17 instructions to wrap the 4-bit counter.
        step(0, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 17; i++) run_instr(1 + (i % 7), 1'(i), 1'b0);
        // Reset while halted, taking effect within the same cycle.
        step(0, 1'b0, 1'b0, -1, 1'b1);
        step(0, 1'b0, 1'b0, -1, 1'b1);
        step(0, 1'b0, 1'b0, -1, 1'b1);
        step(0, 1'b0, 1'b0, -1, 1'b0);
        step(2, 1'b0, 1'b0, -1, 1'b1);
        run_instr(2, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
